// File: rtl/fetch_unit.sv
// Instruction fetch unit and architectural PC register for the RISC-V core.
// Optional misaligned-target trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] NEXT_PC,
   input  logic        EXEC_DONE,
   input  logic        IMEM_ACK,
   input  logic [31:0] IMEM_DATA,
   output logic [31:0] PC,
   output logic        HOLD,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   output logic [31:0] INSTR,
   output logic        INSTR_VALID,
   output logic        FETCH_ERR,
   output logic        MISALIGN
);

   localparam int              CW        = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0]   CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_MAX   = '1;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      EXEC,
      ERROR
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            fetch_err_q, fetch_err_d;
`ifdef FETCH_ALIGN_CHECK_EN
   logic            misalign_q, misalign_d;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         pc_q        <= RESET_VECTOR;
         instr_q     <= '0;
         cnt_q       <= '0;
         fetch_err_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         misalign_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         cnt_q       <= cnt_d;
         fetch_err_q <= fetch_err_d;
`ifdef FETCH_ALIGN_CHECK_EN
         misalign_q  <= misalign_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      cnt_d       = cnt_q;
      fetch_err_d = fetch_err_q;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_d  = misalign_q;
`endif
      case (state_q)
         IDLE: begin
            state_d = FETCH;
            cnt_d   = '0;
         end
         FETCH: begin
            // An acknowledge in the timeout cycle still wins over the error.
            if (IMEM_ACK) begin
               instr_d = IMEM_DATA;
               cnt_d   = '0;
               state_d = EXEC;
            end else if (cnt_q >= CNT_LIMIT) begin
               fetch_err_d = 1'b1;
               state_d     = ERROR;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         EXEC: begin
            if (EXEC_DONE) begin
`ifdef FETCH_ALIGN_CHECK_EN
               if (NEXT_PC[1:0] != 2'b00) begin
                  misalign_d  = 1'b1;
                  fetch_err_d = 1'b1;
                  state_d     = ERROR;
               end else begin
                  pc_d    = NEXT_PC;
                  state_d = FETCH;
               end
`else
               pc_d    = NEXT_PC & 32'hFFFF_FFFC;
               state_d = FETCH;
`endif
            end
         end
         ERROR: begin
            state_d = ERROR;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign PC          = pc_q;
   assign IMEM_ADDR   = pc_q;
   assign INSTR       = instr_q;
   assign IMEM_REQ    = (state_q == FETCH);
   assign HOLD        = (state_q != EXEC);
   assign INSTR_VALID = (state_q == EXEC);
   assign FETCH_ERR   = fetch_err_q;
`ifdef FETCH_ALIGN_CHECK_EN
   assign MISALIGN    = misalign_q;
`else
   assign MISALIGN    = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and program-counter register for the RISC-V core. It holds the architectural PC and feeds it to the branch logic. It fetches the instruction at PC over a request/acknowledge instruction-memory port and presents it to decode. When execute signals completion, it loads the next PC computed by the branch logic. It drives the branch logic's HOLD input, so the next-PC adder only advances while an instruction is in execution.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, consecutive unacknowledged request cycles before fetch error; legal range ≥1.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-high reset.
- NEXT_PC  in  32  next PC from branch logic (INCR).
- EXEC_DONE  in  1  current instruction retired; advance PC.
- IMEM_ACK  in  1  instruction memory returns IMEM_DATA this cycle.
- IMEM_DATA  in  32  fetched instruction word.
- PC  out  32  current PC, to branch logic PC input.
- HOLD  out  1  to branch logic HOLD; high unless in EXEC.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  32  fetch address; always equals PC.
- INSTR  out  32  latched instruction word.
- INSTR_VALID  out  1  INSTR is valid for decode.
- FETCH_ERR  out  1  sticky fetch timeout or misalignment error.
- MISALIGN  out  1  sticky misaligned-target flag; tied 0 without FETCH_ALIGN_CHECK_EN.

## Operation
- States: IDLE, FETCH, EXEC, ERROR. Encoding is free.
- Outputs decode from the state register:
  - IMEM_REQ = (state==FETCH).
  - HOLD = (state!=EXEC).
  - INSTR_VALID = (state==EXEC).
  - IMEM_ADDR = PC.
- IDLE: entered only from reset. Moves to FETCH on the next edge unconditionally.
- FETCH:
  - IMEM_REQ is high and the wait counter increments each cycle without IMEM_ACK.
  - On IMEM_ACK: INSTR<=IMEM_DATA, counter<=0, state->EXEC.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ACK, the next edge sets FETCH_ERR<=1 and state->ERROR.
  - ACK in the same cycle as the timeout wins: go to EXEC, no error.
- EXEC:
  - HOLD is low, so the branch logic presents the PC+4, PC+IMM or taken-jump target on NEXT_PC.
  - On EXEC_DONE: PC<=NEXT_PC, state->FETCH.
  - Without EXEC_DONE, PC and INSTR stay stable indefinitely.
- ERROR: REQ low, HOLD high, INSTR_VALID low. The unit stays here until RST.
- IMEM_ACK outside FETCH is ignored. EXEC_DONE outside EXEC is ignored.
- Width rules:
  - The wait counter is $clog2(TIMEOUT_CYCLES)+1 bits and saturates; it does not wrap.
  - PC arithmetic lives in branch logic; this block only loads NEXT_PC. PC wrap from 32'hFFFF_FFFC is whatever NEXT_PC supplies.

## Timing
- Reset values (asynchronous): state=IDLE, PC=RESET_VECTOR, INSTR=0, INSTR_VALID=0, IMEM_REQ=0, HOLD=1, FETCH_ERR=0, MISALIGN=0.
- First IMEM_REQ is high in the second cycle after RST deasserts.
- Fetch latency: ACK sampled at edge k puts INSTR/INSTR_VALID valid from edge k.
- Minimum instruction period is 2 cycles (1 FETCH + 1 EXEC), when ACK comes in the first FETCH cycle and EXEC_DONE in the first EXEC cycle.
- PC changes only on the EXEC->FETCH edge. The new IMEM_ADDR is visible in the same cycle REQ rises.
- RST mid-fetch or mid-exec drops REQ and INSTR_VALID immediately. A late ACK after reset is ignored, because the unit is in IDLE.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - On EXEC_DONE with NEXT_PC[1:0]!=2'b00, PC is not updated.
  - MISALIGN<=1, FETCH_ERR<=1, state->ERROR.
- FETCH_ALIGN_CHECK_EN undefined:
  - PC<=({NEXT_PC[31:2],2'b00}) with no error.
  - MISALIGN is constant 0.

## Test plan
- Reset with RESET_VECTOR=32'h100, ACK in 1st FETCH cycle with IMEM_DATA=32'h00500093 -> REQ at 2nd cycle after reset, IMEM_ADDR=32'h100, INSTR=32'h00500093, INSTR_VALID=1, HOLD=0.
- EXEC, NEXT_PC=32'h104, EXEC_DONE pulse -> PC=32'h104 next edge, REQ=1, HOLD=1; sequence of 4 back-to-back 2-cycle instructions with addresses 100/104/108/10C.
- Taken branch: NEXT_PC=32'h80 on EXEC_DONE -> IMEM_ADDR=32'h80 on next FETCH. EXEC_DONE delayed 5 cycles -> PC, INSTR unchanged for those 5 cycles.
- TIMEOUT_CYCLES=4, no ACK -> FETCH_ERR=1 after 4 REQ cycles, REQ=0, unit stays in ERROR. Repeat with ACK on 4th cycle -> no error, EXEC entered.
- RST asserted in 2nd FETCH cycle, ACK arrives 1 cycle later -> outputs at reset values, INSTR stays 0, normal fetch resumes from RESET_VECTOR.
- NEXT_PC=32'h106 on EXEC_DONE -> with FETCH_ALIGN_CHECK_EN: MISALIGN=1, FETCH_ERR=1, PC unchanged; without it: PC=32'h104, no error.
